adder_pipe_n: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface. It generalises the team's 8-bit combinational full adder to WIDTH bits, split into STAGES registered carry-chained slices. It adds a subtract mode, a signed-overflow flag and back-pressure. It sits between operand producers and the datapath consumers that previously used the combinational adder directly.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_slice.sv | 30 +++
 rtl/adder_pipe_n.sv | 157 +++++++++++++++
 tb/tb_adder_pipe_n.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared helpers for the pipelined adder/subtractor.
//
//   chunk_w(width, stages)   : bits handled by one pipeline slice.
//   stages_ok(width, stages) : geometry check (stages >= 1, stages divides width),
//                              evaluated at elaboration time by adder_pipe_n.
// -----------------------------------------------------------------------------
package adder_pkg;

    // Width of one carry-chained slice. A zero stage count is guarded so the
    // helper itself never divides by zero; stages_ok() rejects that case.
    function automatic int chunk_w(input int width, input int stages);
        return (stages >= 1) ? (width / stages) : width;
    endfunction

    // True when the requested pipeline geometry is legal.
    function automatic bit stages_ok(input int width, input int stages);
        return (stages >= 1) && (width >= 1) && ((width % stages) == 0);
    endfunction

endpackage : adder_pkg

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
//   Combinational W-bit ripple slice: {co, s} = a + b + ci.
//   One instance per pipeline stage; the carry out of slice k is registered and
//   becomes the carry in of slice k+1.
//
//   Ports
//     a, b  in  W   operand bits of this slice (b already inverted for subtract)
//     ci    in  1   carry in
//     s     out W   slice sum
//     co    out 1   carry out of the slice MSB
// -----------------------------------------------------------------------------
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    // Widen to W+1 bits so the carry falls out of the top bit of the sum.
    logic [W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    assign s     = total[W-1:0];
    assign co    = total[W];

endmodule : adder_slice

// File: rtl/adder_pipe_n.sv
// -----------------------------------------------------------------------------
// adder_pipe_n
//   Pipelined two's-complement adder/subtractor with valid/ready handshakes.
//   The WIDTH-bit add is cut into STAGES slices of CHUNK bits; each stage adds
//   one slice using the carry registered by the previous stage. Operands and
//   the partial sum travel with the beat so every stage sees aligned data.
//
//   Parameters
//     WIDTH   operand / sum width (default 8)
//     STAGES  pipeline depth, must divide WIDTH (default 2)
//
//   Ports
//     clk        in   1      clock, rising edge
//     rst        in   1      synchronous active-high reset
//     in_valid   in   1      operand beat valid
//     in_ready   out  1      beat accepted this cycle (combinational from out_ready)
//     a, b       in   WIDTH  operands
//     cin        in   1      carry in
//     sub        in   1      0: a+b+cin, 1: a+~b+cin
//     out_valid  out  1      result valid
//     out_ready  in   1      consumer takes the result
//     s          out  WIDTH  sum / difference
//     cout       out  1      carry out of bit WIDTH-1
//     ovf        out  1      signed overflow
// -----------------------------------------------------------------------------
module adder_pipe_n
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;
    localparam int MSB   = WIDTH - 1;

    // Reject illegal geometry while elaborating rather than building a
    // silently truncated adder.
    if (!stages_ok(WIDTH, STAGES)) begin : g_bad_geometry
        $error("adder_pipe_n: STAGES=%0d must be >= 1 and divide WIDTH=%0d",
               STAGES, WIDTH);
    end

    // -------------------------------------------------------------------------
    // Stage registers. Element k holds the beat that has passed stage k:
    //   a_q / b_q : full operands (b already conditioned by sub)
    //   s_q       : sum bits [0 .. (k+1)*CHUNK-1] valid, upper bits zero
    //   c_q       : carry out of slice k
    //   v_q       : beat present
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];

    logic             advance;
    logic [WIDTH-1:0] b_eff;

    // The whole pipe moves as one: it only stalls when a result is waiting
    // and the consumer is not taking it.
    assign out_valid = v_q[LAST];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    assign b_eff = b ^ {WIDTH{sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [CHUNK-1:0] sum_chunk;
        logic             co;
        logic [WIDTH-1:0] s_next;

        if (k == 0) begin : g_head
            assign a_in = a;
            assign b_in = b_eff;
            assign s_in = '0;
            assign c_in = cin;
            assign v_in = in_valid;
        end else begin : g_body
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign s_in = s_q[k-1];
            assign c_in = c_q[k-1];
            assign v_in = v_q[k-1];
        end

        adder_slice #(
            .W (CHUNK)
        ) u_slice (
            .a  (a_in[k*CHUNK +: CHUNK]),
            .b  (b_in[k*CHUNK +: CHUNK]),
            .ci (c_in),
            .s  (sum_chunk),
            .co (co)
        );

        // Drop this slice's sum into the partial result carried by the beat.
        // NOTE: every variable assigned in always_comb gets a full default first
        // so no path leaves it unassigned, which would infer a latch.
        always_comb begin
            s_next = s_in;
            s_next[k*CHUNK +: CHUNK] = sum_chunk;
        end

        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples the previous stage's pre-edge value, independent of block order.
        // Data registers are reset along with the valid bits so s/cout/ovf read
        // zero after reset; they load only under a valid beat, so operands
        // offered with in_valid=0 never reach the result registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end else if (advance) begin
                v_q[k] <= v_in;
                if (v_in) begin
                    a_q[k] <= a_in;
                    b_q[k] <= b_in;
                    s_q[k] <= s_next;
                    c_q[k] <= co;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result. Overflow is derived from the operand copies that travelled with
    // the beat: same-sign operands producing a sum of the other sign.
    // -------------------------------------------------------------------------
    assign s    = s_q[LAST];
    assign cout = c_q[LAST];
    assign ovf  = (a_q[LAST][MSB] == b_q[LAST][MSB]) &&
                  (s_q[LAST][MSB] != a_q[LAST][MSB]);

endmodule : adder_pipe_n

// File: tb/tb_adder_pipe_n.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe_n
//   Directed checks on an 8-bit / 2-stage instance, then a randomised
//   valid/ready stream on 16-bit / 4-stage and 8-bit / 1-stage instances with
//   in-order scoreboards built from the plain add/subtract equation.
// -----------------------------------------------------------------------------
module tb_adder_pipe_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- 8-bit, 2-stage instance (directed) ----------------
    logic       d_rst = 1'b1, d_in_valid = 1'b0, d_out_ready = 1'b1;
    logic       d_cin = 1'b0, d_sub = 1'b0;
    logic [7:0] d_a = '0, d_b = '0;
    logic       d_in_ready, d_out_valid, d_cout, d_ovf;
    logic [7:0] d_s;

    adder_pipe_n #(.WIDTH(8), .STAGES(2)) u_d (
        .clk(clk), .rst(d_rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .s(d_s), .cout(d_cout), .ovf(d_ovf)
    );

    // ---------------- 16-bit, 4-stage instance (random) ----------------
    logic        x_rst = 1'b1, x_in_valid = 1'b0, x_out_ready = 1'b0;
    logic        x_cin = 1'b0, x_sub = 1'b0;
    logic [15:0] x_a = '0, x_b = '0;
    logic        x_in_ready, x_out_valid, x_cout, x_ovf;
    logic [15:0] x_s;

    adder_pipe_n #(.WIDTH(16), .STAGES(4)) u_x (
        .clk(clk), .rst(x_rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .a(x_a), .b(x_b), .cin(x_cin), .sub(x_sub),
        .out_valid(x_out_valid), .out_ready(x_out_ready),
        .s(x_s), .cout(x_cout), .ovf(x_ovf)
    );

    // ---------------- 8-bit, 1-stage instance (random) ----------------
    logic       y_rst = 1'b1, y_in_valid = 1'b0, y_out_ready = 1'b0;
    logic       y_cin = 1'b0, y_sub = 1'b0;
    logic [7:0] y_a = '0, y_b = '0;
    logic       y_in_ready, y_out_valid, y_cout, y_ovf;
    logic [7:0] y_s;

    adder_pipe_n #(.WIDTH(8), .STAGES(1)) u_y (
        .clk(clk), .rst(y_rst), .in_valid(y_in_valid), .in_ready(y_in_ready),
        .a(y_a), .b(y_b), .cin(y_cin), .sub(y_sub),
        .out_valid(y_out_valid), .out_ready(y_out_ready),
        .s(y_s), .cout(y_cout), .ovf(y_ovf)
    );

    // Reference: {ovf, cout, s} from the add/subtract equation.
    function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] be;
        logic [16:0] t;
        be = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, be} + {16'd0, cin};
        return {(a[15] == be[15]) && (t[15] != a[15]), t[16], t[15:0]};
    endfunction

    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic sub);
        logic [7:0] be;
        logic [8:0] t;
        be = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, be} + {8'd0, cin};
        return {(a[7] == be[7]) && (t[7] != a[7]), t[8], t[7:0]};
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One beat through the idle 8/2 pipe with out_ready held high.
    task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic sub,
                           input logic [7:0] es, input logic ec, input logic eo);
        d_a = a; d_b = b; d_cin = cin; d_sub = sub; d_in_valid = 1'b1;
        step();
        d_in_valid = 1'b0;
        check({tag, "_early"}, {31'd0, d_out_valid}, 32'd0);
        step();
        check({tag, "_valid"}, {31'd0, d_out_valid}, 32'd1);
        check({tag, "_s"},     {24'd0, d_s},         {24'd0, es});
        check({tag, "_cout"},  {31'd0, d_cout},      {31'd0, ec});
        check({tag, "_ovf"},   {31'd0, d_ovf},       {31'd0, eo});
        step();
        check({tag, "_drain"}, {31'd0, d_out_valid}, 32'd0);
    endtask

    logic [17:0] q16[$];
    logic [9:0]  q8[$];
    int          got16, got8, cyc;
    logic [17:0] e16;
    logic [9:0]  e8;

    initial begin
        // ---------------- reset state ----------------
        step();
        step();
        d_rst = 1'b0;
        check("rst_out_valid", {31'd0, d_out_valid}, 32'd0);
        check("rst_s",         {24'd0, d_s},         32'd0);
        check("rst_cout",      {31'd0, d_cout},      32'd0);
        check("rst_ovf",       {31'd0, d_ovf},       32'd0);
        check("rst_in_ready",  {31'd0, d_in_ready},  32'd1);

        // ---------------- directed arithmetic ----------------
        run_one("add_20_13", 8'd20,  8'd13,  1'b0, 1'b0, 8'd33,  1'b0, 1'b0);
        run_one("add_ff_01", 8'hFF,  8'h01,  1'b0, 1'b0, 8'h00,  1'b1, 1'b0);
        run_one("add_7f_01", 8'h7F,  8'h01,  1'b0, 1'b0, 8'h80,  1'b0, 1'b1);
        run_one("sub_5_7",   8'd5,   8'd7,   1'b1, 1'b1, 8'hFE,  1'b0, 1'b0);
        run_one("sub_80_1",  8'h80,  8'h01,  1'b1, 1'b1, 8'h7F,  1'b1, 1'b1);
        run_one("add_cin",   8'h0F,  8'h01,  1'b1, 1'b0, 8'h11,  1'b0, 1'b0);

        // ---------------- back-pressure ----------------
        d_cin = 1'b0; d_sub = 1'b0;
        d_a = 8'd1; d_b = 8'd1; d_in_valid = 1'b1;
        step();
        d_a = 8'd2; d_b = 8'd2;
        step();
        check("bp_first_valid", {31'd0, d_out_valid}, 32'd1);
        check("bp_first_s",     {24'd0, d_s},         32'd2);
        d_out_ready = 1'b0;
        d_a = 8'd3; d_b = 8'd3;
        #1;
        check("bp_in_ready_full", {31'd0, d_in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_valid", {31'd0, d_out_valid}, 32'd1);
            check("bp_hold_s",     {24'd0, d_s},         32'd2);
            check("bp_hold_ready", {31'd0, d_in_ready},  32'd0);
        end
        d_out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, d_in_ready}, 32'd1);
        step();
        check("bp_s4", {24'd0, d_s}, 32'd4);
        d_a = 8'd4; d_b = 8'd4;
        step();
        check("bp_s6", {24'd0, d_s}, 32'd6);
        d_in_valid = 1'b0;
        step();
        check("bp_s8_valid", {31'd0, d_out_valid}, 32'd1);
        check("bp_s8",       {24'd0, d_s},         32'd8);
        step();
        check("bp_empty", {31'd0, d_out_valid}, 32'd0);

        // ---------------- reset mid-flight ----------------
        d_a = 8'd9; d_b = 8'd9; d_in_valid = 1'b1;
        step();
        d_a = 8'd10; d_b = 8'd10;
        step();
        // Beat offered during reset must not be taken.
        d_rst = 1'b1; d_a = 8'd11; d_b = 8'd11;
        step();
        d_rst = 1'b0; d_in_valid = 1'b0;
        check("mid_rst_valid", {31'd0, d_out_valid}, 32'd0);
        check("mid_rst_s",     {24'd0, d_s},         32'd0);
        check("mid_rst_ready", {31'd0, d_in_ready},  32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_rst_quiet", {31'd0, d_out_valid}, 32'd0);
        end

        // ---------------- random streams ----------------
        x_rst = 1'b0; y_rst = 1'b0;
        got16 = 0; got8 = 0; cyc = 0;
        while ((got16 < 1000 || got8 < 1000) && cyc < 10000) begin
            x_in_valid  = ($urandom_range(0, 9) < 7);
            x_out_ready = ($urandom_range(0, 9) < 7);
            x_cin = 1'($urandom); x_sub = 1'($urandom);
            x_a = x_in_valid ? 16'($urandom) : 16'hxxxx;
            x_b = x_in_valid ? 16'($urandom) : 16'hxxxx;
            y_in_valid  = ($urandom_range(0, 9) < 7);
            y_out_ready = ($urandom_range(0, 9) < 7);
            y_cin = 1'($urandom); y_sub = 1'($urandom);
            y_a = y_in_valid ? 8'($urandom) : 8'hxx;
            y_b = y_in_valid ? 8'($urandom) : 8'hxx;
            @(negedge clk);
            if (x_out_valid && x_out_ready) begin
                if (q16.size() == 0) begin
                    check("r16_spurious", 32'd1, 32'd0);
                end else begin
                    e16 = q16.pop_front();
                    check("r16_result", {14'd0, x_ovf, x_cout, x_s}, {14'd0, e16});
                    got16++;
                end
            end
            if (x_in_valid && x_in_ready) q16.push_back(ref16(x_a, x_b, x_cin, x_sub));
            if (y_out_valid && y_out_ready) begin
                if (q8.size() == 0) begin
                    check("r8_spurious", 32'd1, 32'd0);
                end else begin
                    e8 = q8.pop_front();
                    check("r8_result", {22'd0, y_ovf, y_cout, y_s}, {22'd0, e8});
                    got8++;
                end
            end
            if (y_in_valid && y_in_ready) q8.push_back(ref8(y_a, y_b, y_cin, y_sub));
            step();
            cyc++;
        end
        check("r16_count_reached", {31'd0, (got16 >= 1000)}, 32'd1);
        check("r8_count_reached",  {31'd0, (got8 >= 1000)},  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_adder_pipe_n
